wb_arbiter: RTL
===============

# wb_arbiter

Single-write-port scheduler for the register file at the writeback stage. It merges two write sources onto one write port:
- the in-order pipeline writeback result;
- out-of-order results from the long-latency unit (multi-cycle mul/div and late loads), buffered in a small FIFO.

The pipeline has priority. A starvation guard freezes the pipeline for one cycle when a buffered result has waited too long. It also enforces write-after-write ordering and exports a pending-register scoreboard to hazard logic.

## Interface
- DEPTH, 4: long-latency FIFO entries; power of 2, ≥2.
- STARVE_LIMIT, 8: cycles the FIFO head may wait before a forced grant; ≥1.

- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  kills the current pipeline request; the FIFO is unaffected
- pipe_wren_i  in  1  pipeline write request
- pipe_dest_i  in  5  pipeline destination register
- pipe_data_i  in  32  pipeline write data
- lat_valid_i  in  1  long-latency result valid
- lat_dest_i  in  5  long-latency destination register
- lat_data_i  in  32  long-latency write data
- lat_ready_o  out  1  FIFO can accept; a transfer occurs when lat_valid_i && lat_ready_o
- reg_wren_o  out  1  register file write enable (registered)
- w_dest_reg_o  out  5  register file write address (registered)
- reg_wrdata_o  out  32  register file write data (registered)
- stall_o  out  1  freeze pipeline for this cycle (registered)
- busy_o  out  32  bit r set while a live FIFO entry targets register r

## Operation
- Pipeline commit: pipe_wren_i && !flush_i && !stall_o && pipe_dest_i != 0.
- FIFO entry fields: {live, dest, data}. Head pops when granted or when not live.
- Grant priority each cycle:
  - If stall_o: grant the FIFO head (if live); the pipeline request is not serviced and is held by the frozen pipeline.
  - Else if pipeline commit: grant the pipeline.
  - Else: grant the live FIFO head, if any.
- A granted source drives the port registers the next cycle. With no grant, reg_wren_o = 0 and the addr/data registers hold.
- WAW kill: on a pipeline commit to register r, clear live on every FIFO entry with dest r. This includes an entry enqueued in the same cycle.
- Dest 0: a long-latency result with lat_dest_i = 0 is accepted but enqueued not live. A non-live head pops silently in one cycle without a write.
- lat_ready_o = registered count < DEPTH. There is no same-cycle full bypass: a pop while full does not raise ready until the next cycle.
- busy_o is combinational, the OR over live entries of onehot(dest). Bit 0 is always 0.
- Pointer wrap: read/write pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal.

## Timing
- Reset values: reg_wren_o = 0, w_dest_reg_o = 0, reg_wrdata_o = 0, stall_o = 0, FIFO empty, wait counter = 0. After reset lat_ready_o = 1 and busy_o = 0.
- Latency:
  - pipeline request to port: 1 cycle;
  - FIFO enqueue to earliest port write: 2 cycles (enqueue edge, grant edge).
- Wait counter:
  - increments each cycle a live head is present and not granted;
  - clears on head grant, head pop, or empty FIFO.
- Stall: when the counter reaches STARVE_LIMIT, stall_o is high the next cycle for exactly one cycle, and the counter clears. At most one stall cycle per STARVE_LIMIT+1 cycles.
- flush_i and stall_o in the same cycle: the forced grant proceeds and the flush only drops the pipeline request.
- An asynchronous reset mid-operation discards all FIFO contents, with no writes issued.

## Configuration
- WB_ARB_STARVE_EN defined: wait counter and stall_o are implemented as above.
- WB_ARB_STARVE_EN undefined: no counter, stall_o tied to 0. The FIFO drains only in cycles without a pipeline commit, and a continuous pipeline stream can starve it indefinitely.

## Test plan
- Reset, then idle: all outputs 0, lat_ready_o = 1. Enqueue {r5, 0xDEAD_BEEF} → one cycle later reg_wren_o = 1, w_dest_reg_o = 5, reg_wrdata_o = 0xDEADBEEF; busy_o[5] is set for exactly one cycle in between.
- Same-cycle conflict: pipeline writes r3 = 0x11 while the FIFO holds a live r7 = 0x22 → port writes r3 then r7 in consecutive cycles.
- WAW kill: FIFO holds r9 = 0xAA, then the pipeline commits r9 = 0xBB → only 0xBB is written to r9, and busy_o[9] clears on the commit edge.
- Full FIFO (DEPTH = 4) with continuous pipeline writes: lat_ready_o = 0 after 4 accepts. With WB_ARB_STARVE_EN and STARVE_LIMIT = 8, stall_o pulses once per 9 cycles and each pulse drains one entry.
- Dest 0 and flush: enqueue r0 → no write ever, busy_o stays 0. Pipeline request with flush_i = 1 → no write.
- Reset asserted with 3 entries queued → outputs 0 immediately, no writes after release, lat_ready_o = 1.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: schedules pipeline writeback and buffered long-latency results onto one
// register-file write port. Define WB_ARB_STARVE_EN to build the starvation guard (stall_o).
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        pipe_wren_i,
    input  logic [4:0]  pipe_dest_i,
    input  logic [31:0] pipe_data_i,
    input  logic        lat_valid_i,
    input  logic [4:0]  lat_dest_i,
    input  logic [31:0] lat_data_i,
    output logic        lat_ready_o,
    output logic        reg_wren_o,
    output logic [4:0]  w_dest_reg_o,
    output logic [31:0] reg_wrdata_o,
    output logic        stall_o,
    output logic [31:0] busy_o
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("wb_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       dest_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic             wren_q, wren_d, stall_q;
    logic [4:0]       wdest_q, wdest_d;
    logic [31:0]      wdata_q, wdata_d;

    logic          empty, full, head_live, commit, grant_fifo, pop, push, push_live;
    logic [AW-1:0] rd_idx, wr_idx;

    assign rd_idx     = rd_q[AW-1:0];
    assign wr_idx     = wr_q[AW-1:0];
    assign empty      = (wr_q == rd_q);
    assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_live  = !empty && live_q[rd_idx];
    assign commit     = pipe_wren_i && !flush_i && !stall_q && (pipe_dest_i != 5'd0);
    // During a stall the pipeline is frozen, so the head wins even if the pipe asks.
    assign grant_fifo = head_live && (stall_q || !commit);
    assign pop        = !empty && (grant_fifo || !live_q[rd_idx]);
    assign push       = lat_valid_i && !full;
    assign push_live  = (lat_dest_i != 5'd0) && !(commit && lat_dest_i == pipe_dest_i);

    assign wr_d = wr_q + (AW+1)'(push);
    assign rd_d = rd_q + (AW+1)'(pop);

    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++)
            if (commit && dest_q[i] == pipe_dest_i) live_d[i] = 1'b0;
        if (pop)  live_d[rd_idx] = 1'b0;
        if (push) live_d[wr_idx] = push_live;
    end

    always_comb begin
        wren_d  = 1'b0;
        wdest_d = wdest_q;
        wdata_d = wdata_q;
        if (commit) begin
            wren_d  = 1'b1;
            wdest_d = pipe_dest_i;
            wdata_d = pipe_data_i;
        end else if (grant_fifo) begin
            wren_d  = 1'b1;
            wdest_d = dest_q[rd_idx];
            wdata_d = data_q[rd_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            live_q  <= '0;
            wren_q  <= 1'b0;
            wdest_q <= '0;
            wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            live_q  <= live_d;
            wren_q  <= wren_d;
            wdest_q <= wdest_d;
            wdata_q <= wdata_d;
            if (push) begin
                dest_q[wr_idx] <= lat_dest_i;
                data_q[wr_idx] <= lat_data_i;
            end
        end
    end

`ifdef WB_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] wait_q, wait_d, wait_inc;
    logic          stall_d;

    assign wait_inc = wait_q + CW'(1);

    // Reaching the limit arms a one-cycle stall and restarts the count.
    always_comb begin
        wait_d  = '0;
        stall_d = 1'b0;
        if (head_live && !grant_fifo) begin
            if (wait_inc == LIMIT) stall_d = 1'b1;
            else                   wait_d  = wait_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end
`else
    assign stall_q = 1'b0;
`endif

    always_comb begin
        busy_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live_q[i]) busy_o[dest_q[i]] = 1'b1;
        busy_o[0] = 1'b0;
    end

    assign lat_ready_o  = !full;
    assign reg_wren_o   = wren_q;
    assign w_dest_reg_o = wdest_q;
    assign reg_wrdata_o = wdata_q;
    assign stall_o      = stall_q;
endmodule
